// File: rtl/prefix_adder_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder.
package prefix_adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x != 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Associative prefix operator: hi spans the upper bits, lo the bits below it.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/prefix_level.sv
// One combinational Kogge-Stone row: each bit merges with the bit SPAN below it.
module prefix_level
  import prefix_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SPAN  = 1
) (
  input  gp_t [WIDTH-1:0] i_gp,
  output gp_t [WIDTH-1:0] o_gp
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    if (i >= SPAN) begin : g_comb
      assign o_gp[i] = gp_combine(i_gp[i], i_gp[i-SPAN]);
    end else begin : g_pass
      assign o_gp[i] = i_gp[i];
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Latency is 1 + ceil(log2(WIDTH)/REG_EVERY) cycles; one beat per cycle.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned LEVELS = clog2(WIDTH);
  // Register banks ahead of the output register; bank 0 is the g/p stage.
  localparam int unsigned NSEG   = (LEVELS + REG_EVERY - 1) / REG_EVERY;

  logic             w_stall;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_p0;
  logic             w_cin;
  gp_t  [WIDTH-1:0] w_gp0;
  logic [WIDTH-1:0] w_gfin;
  logic [WIDTH-1:0] w_sum;

  gp_t  [WIDTH-1:0] r_gp [NSEG];
  logic [WIDTH-1:0] r_p  [NSEG];
  logic [NSEG-1:0]  r_cin;
  logic [NSEG-1:0]  r_vld;

  gp_t  [WIDTH-1:0] w_in  [1:LEVELS];
  gp_t  [WIDTH-1:0] w_out [1:LEVELS];

  // in_ready is combinational from out_ready so a full pipe can stream.
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // Carry-in is pre-merged into bit 0 so LEVELS rows cover every carry.
  always_comb begin
    w_gp0 = '0;
    w_b   = in_sub ? ~in_b : in_b;
    w_cin = in_sub | in_cin;
    w_p0  = in_a ^ w_b;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_gp0[i].g = in_a[i] & w_b[i];
      w_gp0[i].p = w_p0[i];
    end
    w_gp0[0].g = (in_a[0] & w_b[0]) | (w_p0[0] & w_cin);
  end

  for (genvar k = 1; k <= int'(LEVELS); k++) begin : g_lvl
    if (((k - 1) % REG_EVERY) == 0) begin : g_from_reg
      assign w_in[k] = r_gp[(k-1)/REG_EVERY];
    end else begin : g_from_comb
      assign w_in[k] = w_out[k-1];
    end
    prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (32'(1) << (k - 1))
    ) u_level (
      .i_gp (w_in[k]),
      .o_gp (w_out[k])
    );
  end

  always_comb begin
    w_gfin = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_gfin[i] = w_out[LEVELS][i].g;
    end
    w_sum = r_p[NSEG-1] ^ {w_gfin[WIDTH-2:0], r_cin[NSEG-1]};
  end

  // Whole pipe advances together, bubbles included; a stall freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < int'(NSEG); j++) begin
        r_gp[j] <= '0;
        r_p[j]  <= '0;
      end
      r_cin     <= '0;
      r_vld     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (!w_stall) begin
      r_gp[0]  <= w_gp0;
      r_p[0]   <= w_p0;
      r_cin[0] <= w_cin;
      r_vld[0] <= in_valid;
      for (int j = 1; j < int'(NSEG); j++) begin
        r_gp[j]  <= w_out[j*REG_EVERY];
        r_p[j]   <= r_p[j-1];
        r_cin[j] <= r_cin[j-1];
        r_vld[j] <= r_vld[j-1];
      end
      out_valid <= r_vld[NSEG-1];
      out_sum   <= w_sum;
      out_cout  <= w_gfin[WIDTH-1];
      out_ovf   <= w_gfin[WIDTH-1] ^ w_gfin[WIDTH-2];
    end
  end

endmodule
